// File: rtl/clock_pkg.sv
// Shared defaults and helpers for the clock-enable generator.
package clock_pkg;

  localparam int DEF_DIV   = 4;
  localparam int DEF_EDIV  = 10;
  localparam int DEF_EHIGH = 4;

  // Bits needed to hold a counter that runs 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_enable_generator_mod_counter.sv
// Wrap-around counter 0..N-1 with count enable and synchronous active-low clear.
module mod_counter
  import clock_pkg::*;
#(
  parameter int N = 4,
  parameter int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (en) count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!clr_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/clock_enable_generator.sv
// Derives c1/c3 phases, 7 MHz enable, colour clock, E-clock slots and a turbo CPU
// enable from clk28m as single-domain clock enables.
module clock_enable_generator
  import clock_pkg::*;
#(
  parameter int DIV   = DEF_DIV,
  parameter int EDIV  = DEF_EDIV,
  parameter int EHIGH = DEF_EHIGH
) (
  input  logic            clk28m,
  input  logic            _reset,
  input  logic            turbo,
  output logic            c1,
  output logic            c3,
  output logic            clk7_en,
  output logic            cck,
  output logic            cck_en,
  output logic [EDIV-1:0] eclk,
  output logic            e,
  output logic            cpu_en,
  output logic            turbo_active
);

  localparam int PW = cnt_width(DIV);
  localparam int EW = cnt_width(EDIV);

  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(DIV / 2);
  localparam logic [PW-1:0] PH_Q1    = PW'(DIV / 4);
  localparam logic [PW-1:0] PH_Q3    = PW'(3 * DIV / 4);
  localparam logic [EW-1:0] E_RISE   = EW'(EDIV - EHIGH);

  if ((DIV % 4) != 0 || DIV < 4) begin : g_bad_div
    $error("clock_enable_generator: DIV must be a multiple of 4 and >= 4");
  end
  if ((EDIV % 2) != 0 || EDIV < 4) begin : g_bad_ediv
    $error("clock_enable_generator: EDIV must be even and >= 4");
  end
  if (EHIGH < 1 || EHIGH > EDIV - 1) begin : g_bad_ehigh
    $error("clock_enable_generator: EHIGH must be in 1..EDIV-1");
  end

  logic [PW-1:0] ph;
  logic [EW-1:0] e_cnt;
  logic          run_q, run_d;
  logic          cck_q, cck_d;
  logic          turbo_q, turbo_d;
  logic          tick;

  // ph only starts counting the edge after run rises, so ph=0 lasts one full cycle.
  mod_counter #(.N(DIV), .W(PW)) u_ph (
    .clk   (clk28m),
    .clr_n (_reset),
    .en    (run_q),
    .count (ph)
  );

  mod_counter #(.N(EDIV), .W(EW)) u_e_cnt (
    .clk   (clk28m),
    .clr_n (_reset),
    .en    (tick),
    .count (e_cnt)
  );

  assign tick = run_q && (ph == PH_LAST);

  // turbo is only sampled at a 7 MHz boundary, so cpu_en never produces a runt pulse.
  always_comb begin
    run_d   = 1'b1;
    cck_d   = tick ? ~cck_q : cck_q;
    turbo_d = tick ? turbo  : turbo_q;
  end

  always_ff @(posedge clk28m) begin
    if (!_reset) begin
      run_q   <= 1'b0;
      cck_q   <= 1'b0;
      turbo_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      cck_q   <= cck_d;
      turbo_q <= turbo_d;
    end
  end

  always_comb begin
    c1           = run_q && (ph < PH_HALF);
    c3           = run_q && (ph >= PH_Q1) && (ph < PH_Q3);
    clk7_en      = tick;
    cck          = run_q && cck_q;
    cck_en       = tick && cck_q;
    e            = run_q && (e_cnt >= E_RISE);
    turbo_active = run_q && turbo_q;
    cpu_en       = run_q && (turbo_q || tick);
    eclk         = '0;
    for (int i = 0; i < EDIV; i++) eclk[i] = run_q && (e_cnt == EW'(i));
  end

endmodule
